spi_slave: RTL and testbench

//  SPI mode-0 (CPOL=0, CPHA=0) slave, the far end of our SPI master. MSB-first, 8-bit frames.
//  SCK/nSS/MOSI are synchronised to clk and edge-detected; no second clock domain.
//  Bus side uses the same cmd/wr/rd/dout/ack/irq handshake as the SPI master.

---
 rtl/spi_slave.sv | 201 ++++++++++++++++++++
 tb/tb_spi_slave.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave.sv
// SPI mode-0 slave with single TX/RX buffers, status flags and a strobe/ack bus interface.
// Define SPI_SLAVE_MISO_TRISTATE_EN to release SPI_MISO (1'bz) outside of a frame.
module spi_slave #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  TX_FILL     = 8'hFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] din,
  input  logic        cmd,
  input  logic        wr,
  input  logic        rd,
  output logic [8:0]  dout,
  output logic        ack,
  output logic        irq,
  input  logic        SPI_SCK,
  input  logic        SPI_nSS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO
);

  // Synchroniser plus one flop for edge detection plus one flop for a registered edge pulse.
  localparam int unsigned PipeLen = SYNC_STAGES + 2;

  typedef enum logic [1:0] {StLockout, StIdle, StShift} state_e;

  state_e state_q, state_d;
  logic [PipeLen-1:0] sck_pipe, nss_pipe;
  logic [SYNC_STAGES:0] mosi_pipe;
  logic en_q, en_d, ie_q, ie_d;
  logic [7:0] txbuf_q, txbuf_d, rxbuf_q, rxbuf_d, shr_q, shr_d;
  logic tx_full_q, tx_full_d, rx_full_q, rx_full_d, ovr_q, ovr_d, udr_q, udr_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic miso_q, miso_d;
  logic [8:0] dout_q, dout_d;
  logic ack_q, ack_d, irq_q, irq_d;

  logic sck_rise, sck_fall, nss_rise, nss_fall, nss_lvl, mosi_s;
  logic do_cmd, do_wr, do_rd, rx_clear, tx_load, rx_done, busy;
  logic [7:0] rx_byte, tx_byte;
  logic unused_din;

  assign unused_din = din[8];

  assign sck_rise = sck_pipe[PipeLen-2] & ~sck_pipe[PipeLen-1];
  assign sck_fall = ~sck_pipe[PipeLen-2] & sck_pipe[PipeLen-1];
  assign nss_rise = nss_pipe[PipeLen-2] & ~nss_pipe[PipeLen-1];
  assign nss_fall = ~nss_pipe[PipeLen-2] & nss_pipe[PipeLen-1];
  assign nss_lvl  = nss_pipe[PipeLen-2];
  assign mosi_s   = mosi_pipe[SYNC_STAGES];

  assign busy    = (state_q == StShift);
  assign rx_byte = {shr_q[6:0], mosi_s};
  assign tx_byte = tx_full_q ? txbuf_q : TX_FILL;

  always_comb begin
    state_d   = state_q;
    en_d      = en_q;
    ie_d      = ie_q;
    txbuf_d   = txbuf_q;
    rxbuf_d   = rxbuf_q;
    shr_d     = shr_q;
    tx_full_d = tx_full_q;
    rx_full_d = rx_full_q;
    ovr_d     = ovr_q;
    udr_d     = udr_q;
    bitcnt_d  = bitcnt_q;
    miso_d    = miso_q;
    dout_d    = dout_q;
    tx_load   = 1'b0;
    rx_done   = 1'b0;

    do_cmd   = cmd;
    do_wr    = wr & ~cmd;
    do_rd    = rd & ~cmd & ~wr;
    rx_clear = do_rd & ~din[10];
    ack_d    = cmd | wr | rd;
    irq_d    = ie_q & (rx_full_q | ovr_q | udr_q);

    if (do_cmd) begin
      en_d = din[0];
      ie_d = din[1];
      if (din[9]) begin
        ovr_d = 1'b0;
        udr_d = 1'b0;
      end
    end

    if (do_rd) begin
      dout_d = din[10] ? {1'b0, 3'b000, udr_q, ovr_q, tx_full_q, rx_full_q, busy}
                       : {rx_full_q, rxbuf_q};
    end
    if (rx_clear) rx_full_d = 1'b0;

    if (!en_q) begin
      state_d = StLockout;
    end else begin
      unique case (state_q)
        StLockout: if (nss_lvl) state_d = StIdle;
        StIdle: begin
          if (nss_fall) begin
            tx_load  = 1'b1;
            bitcnt_d = 3'd0;
            state_d  = StShift;
          end
        end
        StShift: begin
          if (nss_rise) begin
            bitcnt_d = 3'd0;
            state_d  = StIdle;
          end else if (sck_rise) begin
            shr_d    = rx_byte;
            bitcnt_d = bitcnt_q + 3'd1;
            if (bitcnt_q == 3'd7) begin
              rx_done = 1'b1;
              tx_load = 1'b1;
            end
          end else if (sck_fall) begin
            miso_d = shr_q[7];
          end
        end
        default: state_d = StLockout;
      endcase
    end

    // A read clearing rx_full in the same cycle frees the buffer for the new byte.
    if (rx_done) begin
      if (!rx_full_q || rx_clear) begin
        rxbuf_d   = rx_byte;
        rx_full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    if (tx_load) begin
      shr_d     = tx_byte;
      miso_d    = tx_byte[7];
      udr_d     = udr_d | ~tx_full_q;
      tx_full_d = 1'b0;
    end

    if (do_wr) begin
      txbuf_d   = din[7:0];
      tx_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sck_pipe  <= '0;
      nss_pipe  <= '0;
      mosi_pipe <= '0;
      state_q   <= StLockout;
      en_q      <= 1'b0;
      ie_q      <= 1'b0;
      txbuf_q   <= 8'h00;
      rxbuf_q   <= 8'h00;
      shr_q     <= 8'h00;
      tx_full_q <= 1'b0;
      rx_full_q <= 1'b0;
      ovr_q     <= 1'b0;
      udr_q     <= 1'b0;
      bitcnt_q  <= 3'd0;
      miso_q    <= 1'b1;
      dout_q    <= 9'h000;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      sck_pipe  <= {sck_pipe[PipeLen-2:0], SPI_SCK};
      nss_pipe  <= {nss_pipe[PipeLen-2:0], SPI_nSS};
      mosi_pipe <= {mosi_pipe[SYNC_STAGES-1:0], SPI_MOSI};
      state_q   <= state_d;
      en_q      <= en_d;
      ie_q      <= ie_d;
      txbuf_q   <= txbuf_d;
      rxbuf_q   <= rxbuf_d;
      shr_q     <= shr_d;
      tx_full_q <= tx_full_d;
      rx_full_q <= rx_full_d;
      ovr_q     <= ovr_d;
      udr_q     <= udr_d;
      bitcnt_q  <= bitcnt_d;
      miso_q    <= miso_d;
      dout_q    <= dout_d;
      ack_q     <= ack_d;
      irq_q     <= irq_d;
    end
  end

  assign dout = dout_q;
  assign ack  = ack_q;
  assign irq  = irq_q;

`ifdef SPI_SLAVE_MISO_TRISTATE_EN
  assign SPI_MISO = busy ? miso_q : 1'bz;
`else
  assign SPI_MISO = busy ? miso_q : 1'b1;
`endif

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: bus register vectors from a table, then SPI frame sequences.
module tb_spi_slave;

  localparam int unsigned SYNC = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic [10:0] din;
  logic        cmd, wr, rd;
  logic [8:0]  dout;
  logic        ack, irq;
  logic        sck, nss, mosi;
  wire         miso;

  int errors = 0;
  int checks = 0;

  spi_slave #(.SYNC_STAGES(SYNC), .TX_FILL(8'hFF)) dut (
    .clk     (clk),
    .rst     (rst),
    .din     (din),
    .cmd     (cmd),
    .wr      (wr),
    .rd      (rd),
    .dout    (dout),
    .ack     (ack),
    .irq     (irq),
    .SPI_SCK (sck),
    .SPI_nSS (nss),
    .SPI_MOSI(mosi),
    .SPI_MISO(miso)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        cmd;
    logic        wr;
    logic        rd;
    logic [10:0] din;
    logic        ack;
    logic [8:0]  dout;
    logic        irq;
  } vec_t;

  vec_t vecs[11];

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one bus strobe for a single cycle; its ack/dout are visible on return.
  task automatic bus(input logic c, input logic w, input logic r, input logic [10:0] d);
    cmd = c; wr = w; rd = r; din = d;
    @(negedge clk);
    cmd = 1'b0; wr = 1'b0; rd = 1'b0; din = 11'h000;
  endtask

  task automatic sck_pulses(input int n, input int half);
    for (int p = 0; p < n; p++) begin
      sck = 1'b1;
      repeat (half) @(negedge clk);
      sck = 1'b0;
      repeat (half) @(negedge clk);
    end
  endtask

  // Master-side frame; optional bus op in the low phase after bit mid_i.
  task automatic spi_frame(input logic [15:0] mo, input int nbits, input int half,
                           input int mid_i, input bit mid_wr, input logic [10:0] mid_din,
                           output logic [15:0] mi, output int lat, output logic [8:0] mid_dout);
    mi = '0;
    lat = -1;
    mid_dout = '0;
    nss = 1'b0;
    mosi = mo[nbits-1];
    repeat (half) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      mi = {mi[14:0], miso};
      sck = 1'b1;
      for (int k = 1; k <= half; k++) begin
        @(negedge clk);
        if (i == nbits - 1 && lat < 0 && irq) lat = k;
      end
      sck = 1'b0;
      if (i < nbits - 1) mosi = mo[nbits-2-i];
      if (i == mid_i) begin
        if (mid_wr) wr = 1'b1;
        else rd = 1'b1;
        din = mid_din;
        @(negedge clk);
        wr = 1'b0;
        rd = 1'b0;
        din = 11'h000;
        mid_dout = dout;
        repeat (half - 1) @(negedge clk);
      end else begin
        repeat (half) @(negedge clk);
      end
    end
    nss = 1'b1;
    repeat (half) @(negedge clk);
  endtask

  logic [15:0] mi;
  int          lat;
  logic [8:0]  mdout;

  initial begin
    //            cmd   wr    rd    din      ack   dout    irq
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 11'h400, 1'b1, 9'h000, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 11'h003, 1'b1, 9'h000, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 11'h000, 1'b0, 9'h000, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 11'h05A, 1'b1, 9'h000, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b1, 11'h400, 1'b1, 9'h004, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 11'h000, 1'b1, 9'h000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b1, 11'h401, 1'b1, 9'h000, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 11'h400, 1'b1, 9'h004, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 11'h0A5, 1'b1, 9'h004, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 11'h003, 1'b1, 9'h004, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 11'h400, 1'b1, 9'h004, 1'b0};

    rst = 1'b1; cmd = 1'b0; wr = 1'b0; rd = 1'b0; din = 11'h000;
    sck = 1'b0; nss = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_dout", 16'(dout), 16'h000);
    check("reset_ack", 16'(ack), 16'h0);
    check("reset_irq", 16'(irq), 16'h0);
    check("reset_miso", 16'(miso), 16'h1);

    for (int i = 0; i < 11; i++) begin
      bus(vecs[i].cmd, vecs[i].wr, vecs[i].rd, vecs[i].din);
      check($sformatf("vec%0d_ack", i), 16'(ack), 16'(vecs[i].ack));
      check($sformatf("vec%0d_dout", i), 16'(dout), 16'(vecs[i].dout));
      check($sformatf("vec%0d_irq", i), 16'(irq), 16'(vecs[i].irq));
    end
    check("single_ack_pulse", 16'(ack), 16'h1);
    @(negedge clk);
    check("ack_drops", 16'(ack), 16'h0);
    repeat (8) @(negedge clk);

    // 1: basic frame, next TX byte written mid-frame is consumed and not returned
    spi_frame(16'h003C, 8, 8, 3, 1'b1, 11'h077, mi, lat, mdout);
    check("t1_miso", mi[7:0], 16'h00A5);
    check("t1_irq_latency", 16'(lat), 16'(SYNC + 3));
    check("t1_irq", 16'(irq), 16'h1);
    bus(1'b0, 1'b0, 1'b1, 11'h000);
    check("t1_rd", 16'(dout), 16'h13C);
    repeat (2) @(negedge clk);
    check("t1_irq_drop", 16'(irq), 16'h0);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t1_status", 16'(dout), 16'h000);

    // 2: underrun
    spi_frame(16'h005A, 8, 8, -1, 1'b0, 11'h000, mi, lat, mdout);
    check("t2_miso_fill", mi[7:0], 16'h00FF);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t2_status_udr", 16'(dout), 16'h012);
    check("t2_irq", 16'(irq), 16'h1);
    bus(1'b1, 1'b0, 1'b0, 11'h203);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t2_status_clr", 16'(dout), 16'h002);
    bus(1'b0, 1'b0, 1'b1, 11'h000);
    check("t2_rd", 16'(dout), 16'h15A);

    // 3: overrun keeps the first byte
    spi_frame(16'h0011, 8, 8, -1, 1'b0, 11'h000, mi, lat, mdout);
    spi_frame(16'h0022, 8, 8, -1, 1'b0, 11'h000, mi, lat, mdout);
    bus(1'b0, 1'b0, 1'b1, 11'h000);
    check("t3_rd", 16'(dout), 16'h111);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t3_status_ovr", 16'(dout), 16'h018);
    bus(1'b1, 1'b0, 1'b0, 11'h203);

    // 4: aborted partial frame, then a full one
    spi_frame(16'h001F, 5, 8, -1, 1'b0, 11'h000, mi, lat, mdout);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t4_status_partial", 16'(dout), 16'h010);
    spi_frame(16'h0081, 8, 8, -1, 1'b0, 11'h000, mi, lat, mdout);
    bus(1'b0, 1'b0, 1'b1, 11'h000);
    check("t4_rd", 16'(dout), 16'h181);
    bus(1'b1, 1'b0, 1'b0, 11'h203);

    // 5: reset mid-frame, bus ignored until nSS goes high
    nss = 1'b0;
    mosi = 1'b1;
    repeat (8) @(negedge clk);
    sck_pulses(3, 8);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5_rst_miso", 16'(miso), 16'h1);
    check("t5_rst_dout", 16'(dout), 16'h000);
    bus(1'b1, 1'b0, 1'b0, 11'h003);
    sck_pulses(4, 8);
    check("t5_lockout_miso", 16'(miso), 16'h1);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t5_lockout_status", 16'(dout), 16'h000);
    nss = 1'b1;
    repeat (8) @(negedge clk);
    bus(1'b0, 1'b1, 1'b0, 11'h0C3);
    spi_frame(16'h0096, 8, 8, -1, 1'b0, 11'h000, mi, lat, mdout);
    check("t5_miso", mi[7:0], 16'h00C3);
    bus(1'b0, 1'b0, 1'b1, 11'h000);
    check("t5_rd", 16'(dout), 16'h196);

    // 6: back-to-back bytes at 4 clk per SCK, first byte read mid-frame
    bus(1'b1, 1'b0, 1'b0, 11'h203);
    spi_frame(16'hA15E, 16, 2, 11, 1'b0, 11'h000, mi, lat, mdout);
    repeat (10) @(negedge clk);
    check("t6_rd_first", 16'(mdout), 16'h1A1);
    bus(1'b0, 1'b0, 1'b1, 11'h000);
    check("t6_rd_second", 16'(dout), 16'h15E);
    bus(1'b0, 1'b0, 1'b1, 11'h400);
    check("t6_status", 16'(dout), 16'h010);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
